// File: rtl/rst_seq.sv
// rst_seq: async-assert / sync-release reset sequencer, releasing NUM_CH channels in order.
// Define RST_SEQ_SWRST_EN to let sw_rst restart the sequence without clearing the synchroniser.
module rst_seq #(
   parameter int NUM_CH      = 4,
   parameter int DELAY       = 50,
   parameter int GAP         = 8,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              sw_rst,
   output logic [NUM_CH-1:0] rstn_out,
   output logic              done,
   output logic [3:0]        stage
);
   typedef enum logic [1:0] {HOLD, WAIT, STEP, DONE} state_t;
   state_t                 st;
   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt;
   logic                   sw;
`ifdef RST_SEQ_SWRST_EN
   assign sw = sw_rst;
`else
   logic unused_sw;
   assign unused_sw = sw_rst;
   assign sw = 1'b0;
`endif
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) sync_q <= '0;
      else sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st       <= HOLD;
         cnt      <= '0;
         rstn_out <= '0;
         done     <= 1'b0;
         stage    <= '0;
      end else if (sw) begin
         st       <= HOLD;
         cnt      <= '0;
         rstn_out <= '0;
         done     <= 1'b0;
         stage    <= '0;
      end else begin
         case (st)
            HOLD: if (sync_q[SYNC_STAGES-1]) begin
               st  <= WAIT;
               cnt <= CNT_W'(DELAY - 1);
            end
            WAIT, STEP: if (cnt != '0) cnt <= cnt - 1'b1;
            else begin
               rstn_out <= (rstn_out << 1) | NUM_CH'(1);
               stage    <= stage + 4'd1;
               // the last channel lands in DONE with the counter parked at zero
               if (stage == 4'(NUM_CH - 1)) begin
                  st   <= DONE;
                  done <= 1'b1;
                  cnt  <= '0;
               end else begin
                  st  <= STEP;
                  cnt <= CNT_W'(GAP - 1);
               end
            end
            default: cnt <= '0;
         endcase
      end
   end
endmodule

// File: doc/rst_seq.md
RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter NUM_CH, default 4, number of reset output channels (legal 1..8).
REQ-002 Parameter DELAY, default 50, cycles from synchronised deassertion to channel 0 release (legal 1..2**CNT_W-1).
REQ-003 Parameter GAP, default 8, cycles between successive channel releases (legal 1..2**CNT_W-1).
REQ-004 Parameter SYNC_STAGES, default 2, flops in the deassertion synchroniser (legal 2..4).
REQ-005 Parameter CNT_W, default 8, delay counter width.
REQ-006 clk  input  1  single clock; all state on posedge clk.
REQ-007 rst_n  input  1  reset, asynchronous, active-low.
REQ-008 sw_rst  input  1  soft reset request, level, synchronous to clk, active-high.
REQ-009 rstn_out  output  NUM_CH  per-channel active-low resets; bit k released in ascending order.
REQ-010 done  output  1  high when all channels are released.
REQ-011 stage  output  4  number of channels currently released (0..NUM_CH).

Function
REQ-012 The block SHALL assert every rstn_out bit asynchronously when rst_n falls and SHALL deassert synchronously only.
REQ-013 The synchroniser output SHALL rise exactly SYNC_STAGES posedges after the first posedge with rst_n high.
REQ-014 The FSM SHALL have states HOLD, WAIT, STEP and DONE; reset state is HOLD.
REQ-015 HOLD -> WAIT when synchroniser output is high; the counter loads DELAY-1 on entry.
REQ-016 In WAIT the counter SHALL decrement each cycle; at 0, rstn_out[0] rises, stage becomes 1, counter loads GAP-1, FSM -> STEP (or -> DONE if NUM_CH=1).
REQ-017 rstn_out[0] SHALL rise exactly DELAY posedges after the synchroniser output rises.
REQ-018 In STEP, when the counter reaches 0, the next channel SHALL be released and stage incremented; rstn_out[k] rises exactly GAP posedges after rstn_out[k-1].
REQ-019 Releasing channel NUM_CH-1 SHALL move the FSM to DONE, with done rising on the same edge as rstn_out[NUM_CH-1].
REQ-020 Once released, a channel SHALL remain released until rst_n low or an accepted soft reset; no channel releases out of order.
REQ-021 The counter SHALL never wrap; it holds at 0 in HOLD and DONE.
REQ-022 rst_n low at any state, including mid-WAIT or mid-STEP, SHALL immediately clear everything; the next release restarts the full sequence from REQ-013.
REQ-023 An rst_n low pulse shorter than one clock period SHALL still produce a full reset and full restart.

Reset
REQ-024 During rst_n low: rstn_out = all 0, done = 0, stage = 0, counter = 0, synchroniser flops = 0, FSM = HOLD.
REQ-025 No output SHALL toggle between rst_n falling and the synchroniser output rising.

Configuration
REQ-026 Macro RST_SEQ_SWRST_EN defined: sw_rst sampled high at a posedge SHALL, on that edge, drive rstn_out = 0, done = 0, stage = 0 and FSM = HOLD; the synchroniser is not cleared.
REQ-027 With RST_SEQ_SWRST_EN, while sw_rst stays high the block SHALL stay in HOLD; on the first edge sw_rst is low it SHALL go to WAIT and rstn_out[0] rises DELAY posedges later; rst_n low overrides sw_rst.
REQ-028 Macro undefined: sw_rst port SHALL remain present and SHALL be ignored; behaviour is as REQ-012..REQ-025 only.

Verification (NUM_CH=4, DELAY=50, GAP=8, SYNC_STAGES=2; edge 0 = first posedge with rst_n high)
REQ-029 Power-up: release rst_n -> sync high at edge 2; rstn_out = 0001 @52, 0011 @60, 0111 @68, 1111 @76; done=1 and stage=4 @76; stage=0 before 52.
REQ-030 Mid-sequence reset: rst_n low between edges 63 and 64 -> rstn_out = 0000, stage=0 and done=0 without waiting for a clock edge; after re-release the same 52/60/68/76 timing is relative to the new edge 0.
REQ-031 Glitch: 3 ns rst_n low pulse (clock period 10 ns) while in DONE -> all outputs 0 immediately; the full sequence restarts.
REQ-032 Soft reset (macro defined): sw_rst high for cycles 100..104 -> rstn_out = 0000 @100; sequence restarts in WAIT @105; rstn_out[0] rises @155; done @179.
REQ-033 Soft reset (macro undefined): sw_rst high for cycles 100..104 -> no output change; done stays 1.
REQ-034 Corners: NUM_CH=1, DELAY=1, GAP=1 -> rstn_out[0] and done rise together at edge 3; counter never underflows.
